crypt_iter_core: RTL
====================

Name: crypt_iter_core

Overview:
- Parametrised, iterative successor to the 8-bit combinational encrypt/decrypt selector.
- Processes one WIDTH-bit block per transaction through ROUNDS key-mixing rounds, one round per clock.
- Mode (encrypt/decrypt) and key are latched per transaction.
- Valid/ready handshakes on input and output let it sit between a host/UART front end and the output register stage.

Parameters:
- WIDTH, 8: data and key width in bits; legal range 4 or more.
- ROUNDS, 4: rounds per block; legal range 1 to 2**WIDTH-1.
- ROT, 3: left-rotate amount per encrypt round; legal range 1 to WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  host presents a block.
- in_ready  output  1  core can accept a block.
- sel  input  1  1 = encrypt, 0 = decrypt; sampled on accept.
- inp  input  WIDTH  plaintext (encrypt) or ciphertext (decrypt); sampled on accept.
- key  input  WIDTH  cipher key; sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  result block.
- busy  output  1  high while in RUN state.

Behaviour:
- Reset (asynchronous, any state, including mid-round):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out = 0.
  - Round counter = 0; latched sel and key = 0.
  - An in-flight block is discarded.
- Round key: rk(i) = rotl(key_l, i mod WIDTH) XOR i, with i zero-extended or truncated to WIDTH.
- Encrypt round i: x = (rotl(x XOR rk(i), ROT) + rk(i)) mod 2**WIDTH, applied for i = 0 .. ROUNDS-1 in order.
- Decrypt round i: x = rotr((x - rk(i)) mod 2**WIDTH, ROT) XOR rk(i), applied for i = ROUNDS-1 down to 0.
- Decrypt(encrypt(p, k), k) == p for all p, k: this is the exact inverse.
- FSM:
  - IDLE: in_ready = 1. On in_valid at an edge: capture inp into x, capture sel and key, counter = 0, go to RUN.
  - RUN: in_ready = 0, busy = 1. Each edge applies one round and increments the counter. The edge applying the last round (counter == ROUNDS-1) writes x to out, sets out_valid = 1, goes to DONE.
  - DONE: out_valid = 1, out held stable. On out_ready at an edge: out_valid = 0, go to IDLE.
- Latency: out_valid rises exactly ROUNDS edges after the accepting edge.
- Throughput: one block per ROUNDS+2 cycles minimum; no overlap between blocks.
- in_valid while in RUN or DONE: ignored; the host must hold it until in_ready.
- out_ready while out_valid = 0: no effect.
- out keeps its last result after the DONE->IDLE transition until the next result or reset.
- inp, key and sel changing during RUN have no effect on the block in flight.
- ROUNDS = 1: RUN lasts exactly one cycle.
- Arithmetic is modulo 2**WIDTH; carries and borrows are discarded.
- Illegal parameters (ROT == 0, ROT >= WIDTH, ROUNDS == 0) cause an elaboration-time error.

Test Plan:
- Reset then idle: rst pulsed, no stimulus -> in_ready = 1, out_valid = 0, out = 0x00, busy = 0.
- Encrypt, defaults (WIDTH = 8, ROUNDS = 4, ROT = 3): sel = 1, key = 0x00, inp = 0x01 -> out_valid rises 4 edges after accept, out = 0xFD. Round trace 0x08, 0x49, 0x5C, 0xFD.
- Decrypt, defaults: sel = 0, key = 0x00, inp = 0xFD -> out = 0x01 after 4 edges.
- ROUNDS = 1 instance: encrypt key = 0x0F, inp = 0x00 -> out = 0x87 one edge after accept. Decrypt key = 0x0F, inp = 0x87 -> out = 0x00.
- Backpressure and input stability: hold out_ready = 0 for 10 cycles in DONE -> out_valid and out stable, in_ready = 0. Change inp and key during RUN -> result unchanged.
- Reset mid-RUN plus random round-trip: assert rst after 2 rounds -> outputs return to reset values and the next block completes correctly. Run 1000 random (inp, key) pairs, encrypt then decrypt -> original inp recovered every time.

Source files
------------

// File: rtl/crypt_iter_core.sv
// crypt_iter_core: iterative block cipher core, one key-mixing round per clock.
//
// Ports:
//   clk        system clock, rising edge active
//   rst        asynchronous active-high reset
//   in_valid   host presents a block        in_ready   core can accept a block
//   sel        1 = encrypt, 0 = decrypt     inp        input block
//   key        cipher key                   out_valid  result available
//   out_ready  consumer takes the result    out        result block
//   busy       high while rounds are being applied
//
// The handshake is IDLE -> RUN (ROUNDS cycles) -> DONE. Mode, key and block
// are latched on accept; out holds its last value until the next result.

module crypt_iter_core #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ROUNDS = 4,
    parameter int unsigned ROT    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] inp,
    input  logic [WIDTH-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    // Round counter width holds 0..ROUNDS-1; rotation amount holds 0..WIDTH-1.
    localparam int unsigned CW       = (ROUNDS < 2) ? 1 : $clog2(ROUNDS + 1);
    localparam int unsigned RW       = $clog2(WIDTH);
    localparam int unsigned ROT_LAST = (ROUNDS == 0) ? 0 : ((ROUNDS - 1) % WIDTH);

    // Parameter legality, caught at elaboration.
    if (WIDTH < 4) begin : g_bad_width
        $error("crypt_iter_core: WIDTH must be 4 or more");
    end
    if (ROT == 0 || ROT >= WIDTH) begin : g_bad_rot
        $error("crypt_iter_core: ROT must be in 1..WIDTH-1");
    end
    if (ROUNDS == 0 || (ROUNDS >> WIDTH) != 0) begin : g_bad_rounds
        $error("crypt_iter_core: ROUNDS must be in 1..2**WIDTH-1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Variable left-rotate: upper half of the doubled word shifted left.
    function automatic logic [WIDTH-1:0] rotl_var(input logic [WIDTH-1:0] v,
                                                  input logic [RW-1:0]    amt);
        logic [2*WIDTH-1:0] dbl;
        dbl = {v, v} << amt;
        return dbl[2*WIDTH-1 -: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] rotl_k(input logic [WIDTH-1:0] v);
        return {v[WIDTH-ROT-1:0], v[WIDTH-1:WIDTH-ROT]};
    endfunction

    function automatic logic [WIDTH-1:0] rotr_k(input logic [WIDTH-1:0] v);
        return {v[ROT-1:0], v[WIDTH-1:ROT]};
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;       // rounds applied so far
    logic [CW-1:0]    idx_q, idx_d;       // round index i (counts down when decrypting)
    logic [RW-1:0]    rot_q, rot_d;       // i mod WIDTH, tracked alongside idx
    logic [WIDTH-1:0] x_q, x_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] rk;
    logic [WIDTH-1:0] enc_x;
    logic [WIDTH-1:0] dec_x;
    logic [WIDTH-1:0] round_x;
    logic             last_round;

    // One round of the datapath for the current index.
    always_comb begin
        rk         = rotl_var(key_q, rot_q) ^ WIDTH'(idx_q);
        enc_x      = rotl_k(x_q ^ rk) + rk;
        dec_x      = rotr_k(x_q - rk) ^ rk;
        round_x    = sel_q ? enc_x : dec_x;
        last_round = (cnt_q == CW'(ROUNDS - 1));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rot_d       = rot_q;
        x_d         = x_q;
        sel_d       = sel_q;
        key_d       = key_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d        = inp;
                    sel_d      = sel;
                    key_d      = key;
                    cnt_d      = '0;
                    // Decrypt walks the round keys in reverse order.
                    idx_d      = sel ? '0 : CW'(ROUNDS - 1);
                    rot_d      = sel ? '0 : RW'(ROT_LAST);
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                x_d   = round_x;
                cnt_d = cnt_q + CW'(1);
                if (sel_q) begin
                    idx_d = idx_q + CW'(1);
                    rot_d = (rot_q == RW'(WIDTH - 1)) ? '0 : rot_q + RW'(1);
                end else begin
                    idx_d = idx_q - CW'(1);
                    rot_d = (rot_q == '0) ? RW'(WIDTH - 1) : rot_q - RW'(1);
                end
                if (last_round) begin
                    out_d       = round_x;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            rot_q       <= '0;
            x_q         <= '0;
            sel_q       <= 1'b0;
            key_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rot_q       <= rot_d;
            x_q         <= x_d;
            sel_q       <= sel_d;
            key_q       <= key_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;

endmodule
